// File: rtl/demux_ctrl_pkg.sv
// Shared definitions for the demux dispatch controller.
//   NCH / SEL_W  : channel count and select width of the 1-to-4 demux
//   ST_EMPTY/FULL: encoding of the one-entry buffer FSM
//   next_rr()    : round-robin destination choice given a start pointer
//                  and the per-channel downstream ready vector
package demux_ctrl_pkg;

  localparam int NCH   = 4;
  localparam int SEL_W = 2;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  // Returns the first ready channel scanning ptr, ptr+1, ... (mod 4).
  // Falls back to ptr itself when no channel is ready. The scan runs from
  // the farthest offset down so the nearest ready channel is assigned last.
  function automatic logic [SEL_W-1:0] next_rr(input logic [SEL_W-1:0] ptr,
                                               input logic [NCH-1:0]   ready);
    logic [SEL_W-1:0] idx;
    next_rr = ptr;
    for (int i = NCH - 1; i >= 0; i--) begin
      idx = ptr + SEL_W'(i);
      if (ready[idx]) next_rr = idx;
    end
  endfunction

endpackage

// File: rtl/demux_valid_dec.sv
// Combinational 1x4 demultiplexer of the busy line.
//   busy      : data line (buffer holds an undelivered word)
//   sel       : select, sel[1] = A (MSB), sel[0] = B
//   out_valid : one-hot copy of busy on channel sel, all zero when idle
module demux_valid_dec
  import demux_ctrl_pkg::*;
(
  input  logic             busy,
  input  logic [SEL_W-1:0] sel,
  output logic [NCH-1:0]   out_valid
);

  logic a_n;
  logic b_n;

  not u_inv_a (a_n, sel[1]);
  not u_inv_b (b_n, sel[0]);

  and u_and0 (out_valid[0], busy, a_n,    b_n);
  and u_and1 (out_valid[1], busy, a_n,    sel[0]);
  and u_and2 (out_valid[2], busy, sel[1], b_n);
  and u_and3 (out_valid[3], busy, sel[1], sel[0]);

endmodule

// File: rtl/demux_dispatch_ctrl.sv
// Sequencing controller for a 1-to-4 demux datapath.
// Accepts one word at a time into a one-entry buffer and offers it to
// exactly one downstream channel, chosen at accept time either from
// in_addr (mode=0) or round-robin over ready channels (mode=1).
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : upstream handshake, in_data/in_addr/mode payload
//   out_data/out_valid  : buffered word and one-hot channel offer
//   out_ready           : per-channel downstream ready
//   sel                 : demux select of the buffered word
//   busy                : buffer FSM is FULL (also exposes the FSM state)
//   cnt_clr / cnt_flat  : clear and packed readout of delivery counters
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Upstream: accept = in_valid & in_ready. Downstream:
// fire = out_valid[k] & out_ready[k]. Once offered, a word is held stable
// on its channel until it fires; ready may depend combinationally on the
// downstream ready (accept-while-draining), valid never depends on ready.
module demux_dispatch_ctrl
  import demux_ctrl_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
)(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [DATA_W-1:0]    in_data,
  input  logic [SEL_W-1:0]     in_addr,
  input  logic                 mode,
  output logic                 in_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic [NCH-1:0]       out_valid,
  input  logic [NCH-1:0]       out_ready,
  output logic [SEL_W-1:0]     sel,
  output logic                 busy,
  input  logic                 cnt_clr,
  output logic [NCH*CNT_W-1:0] cnt_flat
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [0:0]       state_q;
  logic [SEL_W-1:0] rr_ptr;
  logic [CNT_W-1:0] cnt_q [NCH];
  logic             fire;
  logic             accept;
  logic [SEL_W-1:0] dest;

  assign busy = (state_q == ST_FULL);
  assign fire = busy & out_ready[sel];

  // Held low during reset so nothing is accepted while the buffer is cleared.
  assign in_ready = rst_n & (~busy | fire);
  assign accept   = in_valid & in_ready;

  assign dest = mode ? next_rr(rr_ptr, out_ready) : in_addr;

  demux_valid_dec u_valid_dec (
    .busy      (busy),
    .sel       (sel),
    .out_valid (out_valid)
  );

  // Buffer FSM, payload and select. An accept always wins over a drain so
  // back-to-back words flow with no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_EMPTY;
      out_data <= '0;
      sel      <= '0;
      rr_ptr   <= '0;
    end else begin
      if (accept) begin
        state_q  <= ST_FULL;
        out_data <= in_data;
        sel      <= dest;
        if (mode) rr_ptr <= dest + SEL_W'(1);
      end else if (fire) begin
        state_q <= ST_EMPTY;
      end
    end
  end

  // Saturating delivery counters; clear has priority over a same-cycle fire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCH; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (cnt_clr) begin
          cnt_q[k] <= '0;
        end else if (fire && (sel == SEL_W'(k)) && (cnt_q[k] != CNT_MAX)) begin
          cnt_q[k] <= cnt_q[k] + CNT_W'(1);
        end
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_cnt_flat
    assign cnt_flat[g*CNT_W +: CNT_W] = cnt_q[g];
  end

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Self-checking bench for demux_dispatch_ctrl (CNT_W=2 so saturation is
// reachable). A behavioural model tracks the buffered word, its channel,
// the round-robin pointer and delivery counts; a compare process checks all
// outputs every negedge, and directed sections add literal expectations.
module tb_demux_dispatch_ctrl;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 2;
  localparam int CMAX   = 3;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [1:0]        in_addr;
  logic              mode;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic [3:0]        out_valid;
  logic [3:0]        out_ready;
  logic [1:0]        sel;
  logic              busy;
  logic              cnt_clr;
  logic [4*CNT_W-1:0] cnt_flat;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 0;

  // Behavioural model state
  bit        m_full;
  int        m_data;
  int        m_dest;
  int        m_rr;
  int        m_cnt [4];

  demux_dispatch_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_addr   (in_addr),
    .mode      (mode),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel       (sel),
    .busy      (busy),
    .cnt_clr   (cnt_clr),
    .cnt_flat  (cnt_flat)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checker helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_full = 0; m_data = 0; m_dest = 0; m_rr = 0;
      for (int k = 0; k < 4; k++) m_cnt[k] = 0;
    end else begin
      bit f, a;
      int d;
      f = m_full && out_ready[m_dest];
      a = in_valid && (!m_full || f);
      if (cnt_clr) begin
        for (int k = 0; k < 4; k++) m_cnt[k] = 0;
      end else if (f && m_cnt[m_dest] < CMAX) begin
        m_cnt[m_dest] = m_cnt[m_dest] + 1;
      end
      if (a) begin
        if (mode) begin
          d = m_rr;
          for (int i = 3; i >= 0; i--)
            if (out_ready[(m_rr + i) % 4]) d = (m_rr + i) % 4;
          m_rr = (d + 1) % 4;
        end else begin
          d = in_addr;
        end
        m_dest = d;
        m_data = in_data;
        m_full = 1;
      end else if (f) begin
        m_full = 0;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      int exp_cnt;
      check("out_valid", 32'(out_valid), m_full ? (32'd1 << m_dest) : 32'd0);
      check("busy",      32'(busy),      32'(m_full));
      check("out_data",  32'(out_data),  32'(m_data));
      check("sel",       32'(sel),       32'(m_dest));
      check("in_ready",  32'(in_ready),
            32'(rst_n && (!m_full || out_ready[m_dest])));
      exp_cnt = m_cnt[0] | (m_cnt[1] << 2) | (m_cnt[2] << 4) | (m_cnt[3] << 6);
      check("cnt_flat",  32'(cnt_flat),  32'(exp_cnt));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit v, input logic [7:0] d, input logic [1:0] a,
                       input bit m, input logic [3:0] r, input bit c);
    in_valid = v; in_data = d; in_addr = a; mode = m; out_ready = r; cnt_clr = c;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_clear();
    drive(0, 8'h00, 2'd0, 0, 4'b1111, 0);
    step();
    step();
    drive(0, 8'h00, 2'd0, 0, 4'b1111, 1);
    step();
    drive(0, 8'h00, 2'd0, 0, 4'b1111, 0);
  endtask

  // ---------------- stimulus ----------------
  logic [3:0] ov_lit [4];
  logic [1:0] rr_lit [6];

  initial begin
    ov_lit[0] = 4'b0001; ov_lit[1] = 4'b0010; ov_lit[2] = 4'b0100; ov_lit[3] = 4'b1000;
    rr_lit[0] = 2'd0; rr_lit[1] = 2'd1; rr_lit[2] = 2'd2;
    rr_lit[3] = 2'd3; rr_lit[4] = 2'd0; rr_lit[5] = 2'd1;

    rst_n = 1'b0;
    drive(0, 8'h00, 2'd0, 0, 4'b0000, 0);
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_en = 1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_sel",       32'(sel),       32'd0);
    check("reset_cnt",       32'(cnt_flat),  32'd0);

    // Addressed dispatch, back-to-back
    for (int i = 0; i < 4; i++) begin
      drive(1, 8'((i + 1) * 8'h11), 2'(i), 0, 4'b1111, 0);
      step();
      check("addr_out_valid", 32'(out_valid), 32'(ov_lit[i]));
      check("addr_out_data",  32'(out_data),  32'((i + 1) * 17));
    end
    drive(0, 8'h00, 2'd0, 0, 4'b1111, 0);
    step();
    check("addr_busy_after", 32'(busy), 32'd0);
    check("addr_counts", 32'(cnt_flat), 32'h55);

    // Round-robin wrap
    idle_clear();
    for (int i = 0; i < 6; i++) begin
      drive(1, 8'($urandom), 2'd3, 1, 4'b1111, 0);
      step();
      check("rr_sel", 32'(sel), 32'(rr_lit[i]));
    end
    drive(0, 8'h00, 2'd0, 1, 4'b1111, 0);
    step();
    check("rr_counts", 32'(cnt_flat), 32'h5A);

    // Round-robin skip: rr_ptr=2 now; steer to 0 so rr_ptr becomes 1
    drive(1, 8'hA0, 2'd0, 1, 4'b0001, 0);
    step();
    check("rr_to0_sel", 32'(sel), 32'd0);
    drive(1, 8'hA1, 2'd0, 1, 4'b1001, 0);
    step();
    check("rr_skip_sel", 32'(sel), 32'd3);
    drive(0, 8'h00, 2'd0, 1, 4'b1001, 0);
    step();
    drive(1, 8'hA2, 2'd2, 1, 4'b0000, 0);
    step();
    check("rr_none_sel", 32'(sel), 32'd0);
    drive(0, 8'h00, 2'd2, 1, 4'b0000, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rr_hold_valid", 32'(out_valid), 32'b0001);
    end
    drive(0, 8'h00, 2'd2, 1, 4'b0001, 0);
    step();
    check("rr_released", 32'(busy), 32'd0);

    // Backpressure / hold on channel 2
    drive(1, 8'hC3, 2'd2, 0, 4'b0000, 0);
    step();
    for (int i = 0; i < 5; i++) begin
      drive(1, 8'($urandom), 2'(i), 1'(i), 4'b1011, 0);
      #1;
      check("bp_in_ready", 32'(in_ready), 32'd0);
      step();
      check("bp_out_data", 32'(out_data), 32'hC3);
      check("bp_sel",      32'(sel),      32'd2);
    end
    drive(1, 8'h3C, 2'd1, 0, 4'b0100, 0);
    #1;
    check("bp_ready_fire", 32'(in_ready), 32'd1);
    step();
    check("bp_next_data", 32'(out_data), 32'h3C);
    check("bp_next_sel",  32'(sel),      32'd1);

    // Counter saturation on channel 1, then clear coincident with fire
    idle_clear();
    for (int i = 0; i < 5; i++) begin
      drive(1, 8'(i), 2'd1, 0, 4'b0010, 0);
      step();
    end
    drive(0, 8'h00, 2'd1, 0, 4'b0010, 0);
    step();
    check("sat_count", 32'(cnt_flat), 32'h0C);
    drive(1, 8'h77, 2'd1, 0, 4'b0000, 0);
    step();
    drive(0, 8'h00, 2'd1, 0, 4'b0010, 1);
    step();
    check("clr_vs_fire", 32'(cnt_flat), 32'h00);

    // Reset mid-FULL
    drive(1, 8'h5A, 2'd2, 0, 4'b0000, 0);
    step();
    check("pre_rst_valid", 32'(out_valid), 32'b0100);
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_sel",       32'(sel),       32'd0);
    check("rst_cnt2",      32'(cnt_flat[5:4]), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    step();
    rst_n = 1'b1;

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, 8'($urandom), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 4'($urandom), $urandom_range(0, 40) == 0);
      step();
    end

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
